// File: rtl/frame_parser_subordinate.sv
// frame_parser_subordinate: receive-side AXI-Stream frame parser.
// Checks a two-beat header, forwards payload beats to a FIFO write port,
// checks the trailer beat, and reports per-frame status and saturating counters.
// Optional feature macro: FRAME_PARSER_BCAST_EN (also accept the broadcast destination).
module frame_parser_subordinate #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter logic [23:0] TRAILER_WORD = 24'h005704
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic [7:0]            S_AXIS_tkeep,
    input  logic                  S_AXIS_tvalid,
    input  logic                  S_AXIS_tlast,
    output logic                  S_AXIS_tready,
    input  logic                  is_full,
    output logic                  out_wr,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [47:0]           Local_Address,
    input  logic [15:0]           Link_Type,
    input  logic [15:0]           SyncWord,
    input  logic [13:0]           Packet_Size,
    output logic                  frame_done,
    output logic [2:0]            frame_status,
    output logic [CNT_WIDTH-1:0]  frames_ok,
    output logic [CNT_WIDTH-1:0]  frames_bad,
    output logic [1:0]            FPState
);

    localparam int unsigned PS_WIDTH   = 14;
    localparam int unsigned STAT_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_H0      = 2'd0,
        ST_H1      = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t                  state;
    logic [PS_WIDTH-1:0]     pay_cnt;
    logic                    hdr_err;

    logic                    acc;
    logic                    dst_match;
    logic                    h1_err;
    logic [PS_WIDTH-1:0]     exp_len;
    logic                    len_err;
    logic                    trl_err;
    logic [STAT_WIDTH-1:0]   end_status;

    // Stream handshake; held low while reset is asserted
    assign S_AXIS_tready = ARESETN && ((state != ST_PAYLOAD) || !is_full);
    assign acc           = S_AXIS_tvalid && S_AXIS_tready;

    // Payload beats go straight to the FIFO; trailer is never written
    assign out_wr   = acc && (state == ST_PAYLOAD) && !S_AXIS_tlast;
    assign out_data = S_AXIS_tdata;
    assign FPState  = state;

    // Destination address match on the first header beat
`ifdef FRAME_PARSER_BCAST_EN
    assign dst_match = (S_AXIS_tdata[47:0] == Local_Address) ||
                       (S_AXIS_tdata[47:0] == 48'hFFFF_FFFF_FFFF);
`else
    assign dst_match = (S_AXIS_tdata[47:0] == Local_Address);
`endif

    // Second header beat: EtherType and sync word; source address bits ignored
    assign h1_err = (S_AXIS_tdata[47:32] != Link_Type) ||
                    (S_AXIS_tdata[63:48] != SyncWord);

    // Expected payload beats: trailer index minus the two header beats
    assign exp_len = (Packet_Size < PS_WIDTH'(2)) ? '0 : Packet_Size - PS_WIDTH'(2);
    assign len_err = (pay_cnt != exp_len);
    assign trl_err = (S_AXIS_tdata[23:0] != TRAILER_WORD) || (S_AXIS_tkeep != 8'h07);

    // Status reported if the current beat ends the frame
    always_comb begin
        end_status = '0;
        case (state)
            ST_H0:      end_status = 3'b011;
            ST_H1:      end_status = 3'b011;
            ST_PAYLOAD: end_status = {trl_err, len_err, 1'b0};
            ST_DROP:    end_status = 3'b001;
            default:    end_status = 3'b001;
        endcase
    end

    // Parser state, payload counter, status pulse and frame statistics
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= ST_H0;
            pay_cnt      <= '0;
            hdr_err      <= 1'b0;
            frame_done   <= 1'b0;
            frame_status <= '0;
            frames_ok    <= '0;
            frames_bad   <= '0;
        end else begin
            frame_done   <= 1'b0;
            frame_status <= '0;
            if (acc) begin
                if (S_AXIS_tlast) begin
                    frame_done   <= 1'b1;
                    frame_status <= end_status;
                    if (end_status == '0) begin
                        if (frames_ok != '1) frames_ok <= frames_ok + CNT_WIDTH'(1);
                    end else begin
                        if (frames_bad != '1) frames_bad <= frames_bad + CNT_WIDTH'(1);
                    end
                    state   <= ST_H0;
                    pay_cnt <= '0;
                    hdr_err <= 1'b0;
                end else begin
                    case (state)
                        ST_H0: begin
                            hdr_err <= !dst_match;
                            state   <= ST_H1;
                        end
                        ST_H1: begin
                            hdr_err <= hdr_err || h1_err;
                            state   <= (hdr_err || h1_err) ? ST_DROP : ST_PAYLOAD;
                        end
                        ST_PAYLOAD: begin
                            if (pay_cnt != '1) pay_cnt <= pay_cnt + PS_WIDTH'(1);
                        end
                        default: begin
                            state <= ST_DROP;
                        end
                    endcase
                end
            end
        end
    end

endmodule
